// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the native valid/ready memory bus.
package mem_bus_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    localparam logic [3:0]  MEM_WSTRB_READ   = 4'b0000;
    localparam logic [3:0]  MEM_WSTRB_WORD   = 4'b1111;
    localparam logic [31:0] MEM_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_DATA_W-1:0]   wdata;
        logic [MEM_DATA_W/8-1:0] wstrb;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting just after last_grant.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    winner,
    output logic               found
);

    logic [ID_W-1:0] idx_s;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        winner = '0;
        idx_s  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_s  = ID_W'((int'(last_grant) + k) % NUM_REQ);
            winner = req[idx_s] ? idx_s : winner;
        end
    end

    assign found = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort stalled transactions.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]     s_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     s_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   s_wstrb,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic [DATA_W-1:0]             s_rdata,
    output logic                          m_valid,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [DATA_W-1:0]             m_wdata,
    output logic [DATA_W/8-1:0]           m_wstrb,
    input  logic                          m_ready,
    input  logic [DATA_W-1:0]             m_rdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          timeout_err
);

    localparam int                  ID_W    = $clog2(NUM_REQ);
    localparam int                  STRB_W  = DATA_W / 8;
    localparam logic [ID_W-1:0]     LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]  ONE_REQ = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t          state_r;
    logic [ID_W-1:0]     last_grant_r;
    logic [ID_W-1:0]     winner_s;
    logic                found_s;

    logic [ADDR_W-1:0]   req_addr_s  [NUM_REQ];
    logic [DATA_W-1:0]   req_wdata_s [NUM_REQ];
    logic [STRB_W-1:0]   req_wstrb_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_addr_s[g]  = s_addr[g*ADDR_W +: ADDR_W];
        assign req_wdata_s[g] = s_wdata[g*DATA_W +: DATA_W];
        assign req_wstrb_s[g] = s_wstrb[g*STRB_W +: STRB_W];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req        (s_valid),
        .last_grant (last_grant_r),
        .winner     (winner_s),
        .found      (found_s)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMER_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]           timer_r;
`else
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM: grant in IDLE, wait for the memory in BUSY, one bubble in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            m_valid      <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_wstrb      <= '0;
            s_ready      <= '0;
            s_rdata      <= '0;
            grant_id     <= '0;
            last_grant_r <= LAST_ID;
`ifdef MEM_ARB_TIMEOUT_EN
            timer_r      <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        m_addr   <= req_addr_s[winner_s];
                        m_wdata  <= req_wdata_s[winner_s];
                        m_wstrb  <= req_wstrb_s[winner_s];
                        m_valid  <= 1'b1;
                        grant_id <= winner_s;
                        state_r  <= BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                        timer_r  <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (m_ready) begin
                        m_valid      <= 1'b0;
                        s_ready      <= ONE_REQ << grant_id;
                        s_rdata      <= m_rdata;
                        last_grant_r <= grant_id;
                        state_r      <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // Watchdog abort returns a recognisable poison word.
                    else if (timer_r == TIMER_MAX) begin
                        m_valid      <= 1'b0;
                        s_ready      <= ONE_REQ << grant_id;
                        s_rdata      <= DATA_W'(MEM_TIMEOUT_DATA);
                        last_grant_r <= grant_id;
                        timeout_err  <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        timer_r <= timer_r + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    s_ready <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural BRAM and round-robin model.
module tb_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk;
    logic              reset_n;
    logic [N-1:0]      s_valid;
    logic [N*AW-1:0]   s_addr;
    logic [N*DW-1:0]   s_wdata;
    logic [N*DW/8-1:0] s_wstrb;
    logic [N-1:0]      s_ready;
    logic [DW-1:0]     s_rdata;
    logic              m_valid;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_wstrb;
    logic              m_ready;
    logic [DW-1:0]     m_rdata;
    logic [0:0]        grant_id;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] bram      [64];
    logic [31:0] model_mem [64];
    int          model_last;
    logic        stall;
    int          lat;
    int          wait_cnt;

    mem_arbiter #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_valid     (s_valid),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .m_valid     (m_valid),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_ready     (m_ready),
        .m_rdata     (m_rdata),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        return w;
    endfunction

    // Behavioural BRAM: responds lat cycles after seeing a request, write data returned merged.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ready  <= 1'b0;
            m_rdata  <= '0;
            wait_cnt <= 0;
            for (int i = 0; i < 64; i++) bram[i] <= '0;
        end else if (m_valid && !m_ready && !stall) begin
            if (wait_cnt >= lat) begin
                m_ready  <= 1'b1;
                wait_cnt <= 0;
                if (m_wstrb == 4'b0000) begin
                    m_rdata <= bram[m_addr[7:2]];
                end else begin
                    bram[m_addr[7:2]] <= merge(bram[m_addr[7:2]], m_wdata, m_wstrb);
                    m_rdata           <= merge(bram[m_addr[7:2]], m_wdata, m_wstrb);
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
                m_ready  <= 1'b0;
            end
        end else begin
            m_ready <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_next(input logic [N-1:0] pend, input int last);
        for (int k = 1; k <= N; k++) begin
            if (pend[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        model_last = N - 1;
    endtask

    task automatic model_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                             output logic [31:0] rd);
        if (st != 4'b0000) model_mem[a[7:2]] = merge(model_mem[a[7:2]], d, st);
        rd = model_mem[a[7:2]];
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        s_addr[r*AW +: AW]   = a;
        s_wdata[r*DW +: DW]  = d;
        s_wstrb[r*4 +: 4]    = st;
    endtask

    task automatic expect_pulse(input string tag, input int r, input logic [31:0] rd);
        int n;
        logic [N-1:0] oh;
        n  = 0;
        oh = 2'b01 << r;
        while (s_ready == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, 64'(s_ready != '0), 64'd1);
        if (s_ready != '0) begin
            check({tag, "_ready"}, 64'(s_ready), 64'(oh));
            check({tag, "_gid"},   64'(grant_id), 64'(r));
            check({tag, "_rdata"}, 64'(s_rdata), 64'(rd));
        end
        model_last = r;
    endtask

    task automatic txn(input string tag, input int r, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] st);
        logic [31:0] rd;
        model_txn(a, d, st, rd);
        set_req(r, a, d, st);
        s_valid[r] = 1'b1;
        expect_pulse(tag, r, rd);
        s_valid[r] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] ra [N];
        logic [31:0] rdat [N];
        logic [3:0]  rs [N];
        logic [N-1:0] pend;
        int w;
        int cnt0, cnt1, bad, busy, n;

        reset_n = 1'b0;
        s_valid = '0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        stall   = 1'b0;
        lat     = 0;
        model_clear();
        #1;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_addr",  64'(m_addr), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_s_rdata", 64'(s_rdata), 64'd0);
        check("rst_gid",     64'(grant_id), 64'd0);
        check("rst_tmo",     64'(timeout_err), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single read with exact cycle timing
        txn("preload", 0, 32'h04, 32'h55, 4'hF);
        set_req(0, 32'h04, 32'h0, 4'h0);
        s_valid[0] = 1'b1;
        @(negedge clk);
        check("t1_m_valid", 64'(m_valid), 64'd1);
        check("t1_m_addr",  64'(m_addr), 64'h04);
        check("t1_early",   64'(s_ready), 64'd0);
        @(negedge clk);
        check("t1_early2",  64'(s_ready), 64'd0);
        @(negedge clk);
        check("t1_ready",   64'(s_ready), 64'b01);
        check("t1_rdata",   64'(s_rdata), 64'h55);
        s_valid[0] = 1'b0;
        @(negedge clk);
        check("t1_width",   64'(s_ready), 64'd0);
        check("t1_hold",    64'(s_rdata), 64'h55);
        model_last = 0;

        // Contention from a fresh reset: req0 first, then req1
        do_reset();
        set_req(0, 32'h00, 32'hAA, 4'hF);
        set_req(1, 32'h04, 32'h55, 4'hF);
        s_valid = 2'b11;
        pend = 2'b11;
        while (pend != '0) begin
            w = rr_next(pend, model_last);
            model_txn(s_addr[w*AW +: AW], s_wdata[w*DW +: DW], s_wstrb[w*4 +: 4], rd);
            expect_pulse("cont", w, rd);
            s_valid[w] = 1'b0;
            pend[w] = 1'b0;
            @(negedge clk);
        end
        check("cont_last", 64'(model_last), 64'd1);
        txn("rb0", 0, 32'h00, 32'h0, 4'h0);
        check("rb0_val", 64'(s_rdata), 64'hAA);
        txn("rb1", 1, 32'h04, 32'h0, 4'h0);
        check("rb1_val", 64'(s_rdata), 64'h55);

        // Fairness: both request continuously
        set_req(0, 32'h00, 32'h0, 4'h0);
        set_req(1, 32'h04, 32'h0, 4'h0);
        s_valid = 2'b11;
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 8; k++) begin
            w = rr_next(2'b11, model_last);
            check("fair_order", 64'(w), 64'(k % 2));
            model_txn(s_addr[w*AW +: AW], 32'h0, 4'h0, rd);
            expect_pulse("fair", w, rd);
            cnt0 += int'(s_ready[0]);
            cnt1 += int'(s_ready[1]);
            if (k == 7) s_valid = 2'b00;
            @(negedge clk);
        end
        check("fair_cnt0", 64'(cnt0), 64'd4);
        check("fair_cnt1", 64'(cnt1), 64'd4);

        // Request fields are sampled only at grant
        stall = 1'b1;
        set_req(0, 32'h10, 32'h1234_5678, 4'hF);
        s_valid[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("samp_addr0", 64'(m_addr), 64'h10);
        set_req(0, 32'h20, 32'hCAFE_F00D, 4'h3);
        @(negedge clk);
        @(negedge clk);
        check("samp_addr",  64'(m_addr), 64'h10);
        check("samp_wdata", 64'(m_wdata), 64'h1234_5678);
        check("samp_wstrb", 64'(m_wstrb), 64'hF);
        stall = 1'b0;
        model_txn(32'h10, 32'h1234_5678, 4'hF, rd);
        expect_pulse("samp", 0, rd);
        s_valid[0] = 1'b0;
        @(negedge clk);
        txn("samp_rb20", 1, 32'h20, 32'h0, 4'h0);
        txn("samp_rb10", 1, 32'h10, 32'h0, 4'h0);

        // Randomized rounds against the reference model
        for (int round = 0; round < 24; round++) begin
            pend = N'($urandom_range(1, 3));
            lat  = $urandom_range(0, 3);
            for (int r = 0; r < N; r++) begin
                ra[r]   = 32'($urandom_range(0, 15)) << 2;
                rdat[r] = $urandom;
                rs[r]   = 4'($urandom_range(0, 15));
                if (pend[r]) begin
                    set_req(r, ra[r], rdat[r], rs[r]);
                    s_valid[r] = 1'b1;
                end
            end
            while (pend != '0) begin
                w = rr_next(pend, model_last);
                model_txn(ra[w], rdat[w], rs[w], rd);
                expect_pulse("rand", w, rd);
                s_valid[w] = 1'b0;
                pend[w] = 1'b0;
                @(negedge clk);
            end
        end
        lat = 0;

        // Reset in the middle of a stalled transaction
        txn("pre_rst", 0, 32'h00, 32'h0, 4'h0);
        stall = 1'b1;
        set_req(1, 32'h04, 32'h0, 4'h0);
        s_valid[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_m_valid", 64'(m_valid), 64'd1);
        check("mid_gid",     64'(grant_id), 64'd1);
        set_req(0, 32'h00, 32'h0, 4'h0);
        s_valid[0] = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_m_valid", 64'(m_valid), 64'd0);
        check("mrst_s_ready", 64'(s_ready), 64'd0);
        check("mrst_gid",     64'(grant_id), 64'd0);
        check("mrst_m_addr",  64'(m_addr), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        stall = 1'b0;
        model_clear();
        pend = 2'b11;
        while (pend != '0) begin
            w = rr_next(pend, model_last);
            if (pend == 2'b11) check("post_rst_first", 64'(w), 64'd0);
            model_txn(s_addr[w*AW +: AW], 32'h0, 4'h0, rd);
            expect_pulse("post_rst", w, rd);
            s_valid[w] = 1'b0;
            pend[w] = 1'b0;
            @(negedge clk);
        end

        // Stalled downstream
        stall = 1'b1;
        set_req(1, 32'h08, 32'h0, 4'h0);
        s_valid[1] = 1'b1;
        @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
        busy = 0;
        n = 0;
        while (s_ready == '0 && n < 40) begin
            if (m_valid) busy++;
            @(negedge clk);
            n++;
        end
        check("tmo_busy",  64'(busy), 64'd16);
        check("tmo_ready", 64'(s_ready), 64'b10);
        check("tmo_rdata", 64'(s_rdata), 64'hDEAD_BEEF);
        check("tmo_err",   64'(timeout_err), 64'd1);
        s_valid[1] = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        model_last = 1;
`else
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (m_valid !== 1'b1 || s_ready !== '0) bad++;
            @(negedge clk);
        end
        check("stall_hold", 64'(bad), 64'd0);
        check("stall_tmo",  64'(timeout_err), 64'd0);
        stall = 1'b0;
        model_txn(32'h08, 32'h0, 4'h0, rd);
        expect_pulse("stall_end", 1, rd);
        s_valid[1] = 1'b0;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one bram_controller memory port between NUM_REQ requesters, for example a CPU core and a test/pattern sequencer.
- Every port uses the native valid/ready bus: addr, wdata, wstrb (0000 = read) and rdata.
- Each requester sees a private port; the arbiter serialises accesses so that exactly one transaction is outstanding downstream at a time.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- s_valid  in  NUM_REQ  per-requester request valid.
- s_addr  in  NUM_REQ*ADDR_W  per-requester address, packed with requester 0 in the LSBs.
- s_wdata  in  NUM_REQ*DATA_W  per-requester write data.
- s_wstrb  in  NUM_REQ*DATA_W/8  per-requester byte strobes.
- s_ready  out  NUM_REQ  one-hot completion pulse.
- s_rdata  out  DATA_W  read data, shared, valid with s_ready.
- m_valid  out  1  to bram_controller mem_valid.
- m_addr  out  ADDR_W  to mem_addr.
- m_wdata  out  DATA_W  to mem_wdata.
- m_wstrb  out  DATA_W/8  to mem_wstrb.
- m_ready  in  1  from mem_ready.
- m_rdata  in  DATA_W  from mem_rdata.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester (debug).
- timeout_err  out  1  sticky watchdog flag; tied 0 when the feature is off.

Behaviour:
- Reset (async assert, sync release): state=IDLE; m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0; s_ready=0, s_rdata=0, grant_id=0; priority pointer favours requester 0; timeout_err=0.
- A reset mid-transaction abandons the transaction; no s_ready pulse is issued.
- All outputs are registered.

State machine:
- IDLE: if any s_valid is set, pick the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Latch that requester's addr, wdata and wstrb into m_*.
  - Set m_valid=1 and grant_id=winner, then go to BUSY.
  - With no s_valid set, stay in IDLE.
- BUSY: hold m_* stable.
  - When m_ready=1: m_valid<=0, s_ready[grant_id]<=1, s_rdata<=m_rdata (also for writes), last_grant<=grant_id, then go to DONE.
- DONE: s_ready<=0, then go to IDLE. This bubble lets the requester drop s_valid before re-arbitration.

Timing:
- Minimum latency from s_valid rising to s_ready is 3 cycles when m_ready responds the cycle after m_valid: 1 cycle to grant, >=1 cycle in BUSY, 1 cycle to pulse.
- Back-to-back throughput is one transaction per (downstream latency + 3) cycles.
- Simultaneous requests alternate strictly by round-robin.
- A requester that re-asserts immediately after DONE still yields to any other pending requester.

Boundary and protocol rules:
- m_ready is ignored outside BUSY.
- A requester's s_addr, s_wdata and s_wstrb are sampled only at grant; later changes have no effect.
- s_valid dropped by a requester while it is granted is a protocol violation: the transaction still completes and s_ready still pulses.
- s_rdata holds its value between pulses.
- wstrb passes through unchanged. 0000 is a read; any non-zero value is a write.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined: a counter runs in BUSY, cleared on entry.
  - If it reaches TIMEOUT_CYCLES without m_ready, the arbiter forces m_valid<=0 and s_ready[grant_id]<=1 with s_rdata<=32'hDEAD_BEEF.
  - It then sets timeout_err<=1 (sticky until reset) and goes to DONE.
- MEM_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; timeout_err is constant 0.

Decomposition:
- Package mem_bus_pkg:
  - typedef mem_req_t {addr, wdata, wstrb};
  - enum arb_state_t {IDLE, BUSY, DONE};
  - constants MEM_WSTRB_READ=4'b0000, MEM_WSTRB_WORD=4'b1111, MEM_TIMEOUT_DATA=32'hDEAD_BEEF.
- Sub-module rr_picker: combinational priority search of s_valid rotated by last_grant, producing winner index and found flag. Unit-testable on its own.

Test Plan:
1. Single read: req0 reads addr 0x04 with BRAM preloaded 0x55 -> m_valid rises 1 cycle after s_valid; s_ready[0] pulses exactly 1 cycle; s_rdata=0x55; s_ready[1] stays 0.
2. Contention: req0 and req1 both write (0x00 <- 0xAA, 0x04 <- 0x55) in the same cycle -> req0 is granted first, then req1. A readback of both addresses returns 0xAA and 0x55.
3. Fairness: req0 and req1 request continuously for 8 transactions -> grant_id sequence is 0,1,0,1,0,1,0,1 and each requester gets 4 s_ready pulses.
4. Reset mid-BUSY: assert reset_n=0 while m_valid=1 -> all outputs read 0 the same cycle; no s_ready pulse. After release, the next request grants req0.
5. Stalled downstream: m_ready tied 0 and req1 reads.
   - With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: s_ready[1] pulses after 16 BUSY cycles with s_rdata=0xDEADBEEF and timeout_err=1.
   - Without the macro: m_valid remains high for 100 cycles and no s_ready pulse occurs.
6. Sampling: change s_addr of the granted requester during BUSY -> m_addr remains at the originally latched value.
